psram_port_sched: RTL
=====================

# psram_port_sched

Three-port PSRAM access scheduler that sits between the requesters and the PSRAM controller command interface. It shares the single PSRAM burst engine between MCU writes, Game Boy emulation reads and LCD frame reads. Arbitration is round-robin, with an urgent override for emulation reads. Each grant is held as a registered, single-outstanding transaction until the controller signals completion.

## Interface
- WD_CYCLES, 4096: watchdog limit in xClk cycles for one transaction. Used only when the watchdog is compiled in. Must be ≥ 2.
- xClk  in  1  system clock; all logic is on its rising edge.
- xRstN  in  1  reset, asynchronous and active-low.
- xPsramReady  in  1  controller is idle and can accept a command.
- xPsramDone  in  1  single-cycle pulse: the current burst has completed.
- xPsramReqRead / xPsramReqWrite  out  1  single-cycle command strobes to the controller.
- xMemAddress  out  32  burst start address, held for the whole transaction.
- xBurstLength  out  11  burst length, held for the whole transaction.
- xMcuReqWrite, xMcuAddress[31:0], xMcuBurstLength[10:0]  in  port 0: MCU write request.
- xGbReqRead, xGbUrgent, xGbAddress[31:0], xGbBurstLength[10:0]  in  port 1: emulation read request, plus its urgency flag.
- xLcdReqRead, xLcdAddress[31:0], xLcdBurstLength[10:0]  in  port 2: LCD read request.
- xMcuActive / xGbActive / xLcdActive  out  1  port owns the PSRAM. One-hot or all zero.
- xMcuDone / xGbDone / xLcdDone  out  1  single-cycle completion pulse to the owning port.
- xTimeout  out  1  single-cycle pulse on a watchdog abort. Tied to 0 when the watchdog is compiled out.

## Operation
- States: IDLE, BUSY, FLUSH.
- IDLE arbitration:
  - Arbitration is evaluated only when xPsramReady=1 and at least one request is high.
  - Priority order:
    1. xGbReqRead & xGbUrgent.
    2. Round-robin starting at port ptr, checking ptr, ptr+1, ptr+2 (mod 3).
  - The winner's address and length are latched into xMemAddress / xBurstLength.
  - The matching strobe pulses: write for port 0, read for ports 1 and 2.
  - The winner's Active goes high and the state moves to BUSY.
- Zero-length rule: if the winner's length is 0, no strobe is issued.
  - The state goes to FLUSH instead of BUSY, with Active high.
  - Next cycle: Done pulses, Active clears, the state returns to IDLE.
  - ptr rotates as for a normal grant.
- BUSY:
  - Waits for xPsramDone.
  - On Done: next edge pulses the port's Done, clears Active, sets ptr = grant+1 (mod 3) and returns to IDLE.
  - Urgent grants also rotate ptr.
- Request contract:
  - A requester holds Req, Address and Length stable until its Active rises.
  - It deasserts Req no later than the cycle its Done pulses.
  - A Req still high during the Done pulse is treated as a new request.
- Requests are ignored outside IDLE. There is no queueing.
- xPsramReady is ignored outside IDLE.
- xPsramDone arriving in IDLE or FLUSH is ignored.
- Reset (async assert, any state):
  - State IDLE, ptr=0.
  - All strobes, Active, Done and xTimeout are 0.
  - xMemAddress=0, xBurstLength=0.
  - An in-flight transaction is abandoned without a Done pulse.

## Timing
- Request to strobe latency: 1 cycle.
  - If Req and xPsramReady are high at edge N, then from edge N: strobe high for exactly one cycle, Active high, address and length valid.
- xPsramDone sampled high at edge M → Done high and Active low from edge M+1.
- Earliest next strobe: edge M+2, since arbitration resumes in IDLE.
- Zero-length transaction: Active for 1 cycle, Done one cycle after grant.
- Minimum real transaction occupancy: strobe cycle through Done+1.

## Configuration
- PSRAM_SCHED_WATCHDOG_EN defined:
  - A 16-bit counter clears on entering BUSY and increments each BUSY cycle.
  - When the counter reaches WD_CYCLES-1 without xPsramDone, the next edge does all of the following: pulse xTimeout and the owner's Done, clear Active, rotate ptr, return to IDLE.
  - If xPsramDone and expiry coincide, the transaction completes normally and xTimeout stays 0.
- Not defined: no counter; BUSY waits for xPsramDone indefinitely; xTimeout=0.

## Test plan
- Reset, then all three ports request with length 16 and Ready=1 → grants in order MCU, GB, LCD.
  - Each grant gives exactly one strobe (ReqWrite for MCU, ReqRead for GB and LCD).
  - Each Done follows the external xPsramDone by 1 cycle.
- ptr=1 and GB plus LCD requesting; GB urgent asserted while MCU requests from IDLE.
  - Urgent GB wins and xMemAddress equals the GB address.
  - ptr becomes 2 afterwards.
- LCD request with length 0 → no strobe; LcdActive high for 1 cycle; LcdDone pulses next cycle; PSRAM outputs idle.
- Reset asserted mid-BUSY on a GB grant → all outputs 0 immediately (async); no GbDone.
  - After release, the held request is re-granted with a single strobe.
- Watchdog build, WD_CYCLES=8, no xPsramDone → xTimeout and McuDone pulse together 8 cycles after the strobe.
  - A repeat run with xPsramDone on the expiry cycle gives xTimeout=0.
- xPsramReady=0 with pending requests → no strobe and no Active.
  - Ready rising → grant on that same edge.

Source files
------------

// File: rtl/psram_port_sched.sv
// Three-port PSRAM access scheduler: MCU write, GB emulation read and LCD read
// share one PSRAM burst engine. Arbitration is round-robin, and an urgent GB
// read overrides it. Latency: request to strobe is 1 cycle; xPsramDone to port
// Done is 1 cycle. Backpressure: requests wait while xPsramReady=0 or while a
// transaction is held; only one transaction is outstanding and nothing queues.
//
// Ports:
//   xClk, xRstN                   clock, async active-low reset
//   xPsramReady, xPsramDone       controller idle / burst-complete pulse
//   xPsramReqRead/Write           one-cycle command strobes
//   xMemAddress, xBurstLength     held for the whole transaction
//   xMcu*/xGb*/xLcd*              per-port request, Active and Done
//   xTimeout                      watchdog abort pulse
// Optional feature: define PSRAM_SCHED_WATCHDOG_EN to abort a transaction that
// sees no xPsramDone within WD_CYCLES cycles. Otherwise xTimeout is always 0.
module psram_port_sched #(
    parameter int WD_CYCLES = 4096
) (
    input  logic        xClk,
    input  logic        xRstN,
    input  logic        xPsramReady,
    input  logic        xPsramDone,
    output logic        xPsramReqRead,
    output logic        xPsramReqWrite,
    output logic [31:0] xMemAddress,
    output logic [10:0] xBurstLength,
    input  logic        xMcuReqWrite,
    input  logic [31:0] xMcuAddress,
    input  logic [10:0] xMcuBurstLength,
    input  logic        xGbReqRead,
    input  logic        xGbUrgent,
    input  logic [31:0] xGbAddress,
    input  logic [10:0] xGbBurstLength,
    input  logic        xLcdReqRead,
    input  logic [31:0] xLcdAddress,
    input  logic [10:0] xLcdBurstLength,
    output logic        xMcuActive,
    output logic        xGbActive,
    output logic        xLcdActive,
    output logic        xMcuDone,
    output logic        xGbDone,
    output logic        xLcdDone,
    output logic        xTimeout
);

    if (WD_CYCLES < 2) begin : g_wd_bad
        $error("WD_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [1:0]  grant, grant_nxt;
    logic [2:0]  active, active_nxt;
    logic [2:0]  done, done_nxt;
    logic        rd_stb, rd_nxt;
    logic        wr_stb, wr_nxt;
    logic        tmo, tmo_nxt;
    logic [31:0] addr, addr_nxt;
    logic [10:0] blen, blen_nxt;

    // Arbitration result
    logic        win_vld;
    logic [1:0]  win;
    logic [1:0]  c0, c1, c2;
    logic [2:0]  req;
    logic [31:0] win_addr;
    logic [10:0] win_len;

`ifdef PSRAM_SCHED_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(WD_CYCLES - 1);
    logic [15:0] cnt, cnt_nxt;
`endif

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign req = {xLcdReqRead, xGbReqRead, xMcuReqWrite};
    assign c0  = ptr;
    assign c1  = inc3(ptr);
    assign c2  = inc3(c1);

    always_comb begin
        win_vld = 1'b1;
        win     = c0;
        if (xGbReqRead && xGbUrgent) win = 2'd1;
        else if (req[c0])            win = c0;
        else if (req[c1])            win = c1;
        else if (req[c2])            win = c2;
        else                         win_vld = 1'b0;
    end

    always_comb begin
        case (win)
            2'd0:    begin win_addr = xMcuAddress; win_len = xMcuBurstLength; end
            2'd1:    begin win_addr = xGbAddress;  win_len = xGbBurstLength;  end
            default: begin win_addr = xLcdAddress; win_len = xLcdBurstLength; end
        endcase
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        grant_nxt  = grant;
        active_nxt = active;
        done_nxt   = 3'b000;
        rd_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        tmo_nxt    = 1'b0;
        addr_nxt   = addr;
        blen_nxt   = blen;
`ifdef PSRAM_SCHED_WATCHDOG_EN
        cnt_nxt    = cnt;
`endif
        case (state)
            IDLE: begin
                if (xPsramReady && win_vld) begin
                    grant_nxt  = win;
                    addr_nxt   = win_addr;
                    blen_nxt   = win_len;
                    active_nxt = 3'b001 << win;
                    if (win_len == 11'd0) begin
                        // Nothing to transfer: skip the controller entirely.
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt = BUSY;
                        wr_nxt    = (win == 2'd0);
                        rd_nxt    = (win != 2'd0);
`ifdef PSRAM_SCHED_WATCHDOG_EN
                        cnt_nxt   = 16'd0;
`endif
                    end
                end
            end
            BUSY: begin
                // FLUSH doubles as the one-cycle Done stage after xPsramDone.
                if (xPsramDone) begin
                    state_nxt = FLUSH;
                end
`ifdef PSRAM_SCHED_WATCHDOG_EN
                else if (cnt == WD_LAST) begin
                    tmo_nxt    = 1'b1;
                    done_nxt   = active;
                    active_nxt = 3'b000;
                    ptr_nxt    = inc3(grant);
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
`endif
            end
            FLUSH: begin
                done_nxt   = active;
                active_nxt = 3'b000;
                ptr_nxt    = inc3(grant);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge xClk or negedge xRstN) begin
        if (!xRstN) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            grant  <= 2'd0;
            active <= 3'b000;
            done   <= 3'b000;
            rd_stb <= 1'b0;
            wr_stb <= 1'b0;
            tmo    <= 1'b0;
            addr   <= 32'd0;
            blen   <= 11'd0;
`ifdef PSRAM_SCHED_WATCHDOG_EN
            cnt    <= 16'd0;
`endif
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            grant  <= grant_nxt;
            active <= active_nxt;
            done   <= done_nxt;
            rd_stb <= rd_nxt;
            wr_stb <= wr_nxt;
            tmo    <= tmo_nxt;
            addr   <= addr_nxt;
            blen   <= blen_nxt;
`ifdef PSRAM_SCHED_WATCHDOG_EN
            cnt    <= cnt_nxt;
`endif
        end
    end

    assign xPsramReqRead  = rd_stb;
    assign xPsramReqWrite = wr_stb;
    assign xMemAddress    = addr;
    assign xBurstLength   = blen;
    assign xMcuActive     = active[0];
    assign xGbActive      = active[1];
    assign xLcdActive     = active[2];
    assign xMcuDone       = done[0];
    assign xGbDone        = done[1];
    assign xLcdDone       = done[2];
`ifdef PSRAM_SCHED_WATCHDOG_EN
    assign xTimeout       = tmo;
`else
    assign xTimeout       = 1'b0;
`endif

endmodule
